// File: rtl/period_capture_writer_if.sv
// Avalon-MM write-master bundle between period_capture_writer and the sample RAM.
// Latency: none, wires only.
// Backpressure: the slave stalls the master through avm_waitrequest.
interface period_capture_writer_if #(
   parameter int ADDR_W = 10
);
   logic [ADDR_W-1:0] avm_address;
   logic [3:0]        avm_byteenable;
   logic              avm_chipselect;
   logic              avm_write;
   logic [31:0]       avm_writedata;
   logic              avm_waitrequest;

   modport master (
      output avm_address,
      output avm_byteenable,
      output avm_chipselect,
      output avm_write,
      output avm_writedata,
      input  avm_waitrequest
   );

   modport slave (
      input  avm_address,
      input  avm_byteenable,
      input  avm_chipselect,
      input  avm_write,
      input  avm_writedata,
      output avm_waitrequest
   );
endinterface

// File: rtl/period_capture_writer.sv
// Measures sig_in periods and logs them into a RAM ring; PERIOD_CAPTURE_MINMAX_EN adds min/max outputs.
// Latency: edge seen SYNC_STAGES+1 cycles after sig_in rises; write request the cycle after.
// Backpressure: one-entry holding register; a period arriving while it is stalled-full is dropped (overrun).
module period_capture_writer #(
   parameter int ADDR_W      = 10,
   parameter int DEPTH       = 1024,
   parameter int BASE_ADDR   = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    sig_in,
   input  logic                    enable,
   input  logic                    clear,
   period_capture_writer_if.master avm,
   output logic [ADDR_W-1:0]       wr_ptr,
   output logic [31:0]             sample_count,
   output logic                    wrapped,
   output logic                    overrun
`ifdef PERIOD_CAPTURE_MINMAX_EN
   ,
   output logic [31:0]             min_period,
   output logic [31:0]             max_period
`endif
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_MEASURE = 2'd2;

   localparam logic [ADDR_W-1:0] BASE_OFF  = ADDR_W'(BASE_ADDR % DEPTH);
   localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);

   generate
      if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
         $error("period_capture_writer: DEPTH must equal 2**ADDR_W");
      end
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
         $error("period_capture_writer: SYNC_STAGES must be 2..4");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced_d;
   logic                   sig_edge;
   logic [1:0]             state;
   logic [31:0]            cnt;
   logic                   period_vld;
   logic                   hold_full;
   logic [31:0]            hold_dat;
   logic                   commit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q   <= '0;
         synced_d <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
         synced_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sig_edge = sync_q[SYNC_STAGES-1] & ~synced_d;

   // clear outranks everything, then enable=0, then normal sequencing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else if (clear) begin
         state <= enable ? ST_ARMED : ST_IDLE;
         cnt   <= '0;
      end else if (!enable) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: state <= ST_ARMED;
            ST_ARMED: begin
               if (sig_edge) begin
                  state <= ST_MEASURE;
                  cnt   <= 32'd1;
               end
            end
            ST_MEASURE: begin
               if (sig_edge)
                  cnt <= 32'd1;
               else if (cnt != 32'hFFFF_FFFF)
                  cnt <= cnt + 32'd1;
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign period_vld = enable && !clear && (state == ST_MEASURE) && sig_edge;
   assign commit     = hold_full && !avm.avm_waitrequest;

   // A commit frees the slot in the same cycle, so a simultaneous new period is accepted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_full    <= 1'b0;
         hold_dat     <= '0;
         wr_ptr       <= '0;
         sample_count <= '0;
         wrapped      <= 1'b0;
         overrun      <= 1'b0;
      end else if (clear) begin
         hold_full    <= 1'b0;
         wr_ptr       <= '0;
         sample_count <= '0;
         wrapped      <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (commit) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (wr_ptr == LAST_SLOT)
               wrapped <= 1'b1;
            if (sample_count != 32'hFFFF_FFFF)
               sample_count <= sample_count + 32'd1;
         end
         if (period_vld) begin
            if (!hold_full || commit) begin
               hold_full <= 1'b1;
               hold_dat  <= cnt;
            end else begin
               overrun <= 1'b1;
            end
         end else if (commit) begin
            hold_full <= 1'b0;
         end
      end
   end

   assign avm.avm_write      = hold_full;
   assign avm.avm_chipselect = hold_full;
   assign avm.avm_byteenable = {4{hold_full}};
   assign avm.avm_address    = BASE_OFF + wr_ptr;
   assign avm.avm_writedata  = hold_dat;

`ifdef PERIOD_CAPTURE_MINMAX_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         min_period <= 32'hFFFF_FFFF;
         max_period <= '0;
      end else if (clear) begin
         min_period <= 32'hFFFF_FFFF;
         max_period <= '0;
      end else if (period_vld) begin
         if (cnt < min_period)
            min_period <= cnt;
         if (cnt > max_period)
            max_period <= cnt;
      end
   end
`endif

endmodule

// File: tb/tb_period_capture_writer.sv
// Directed/randomized bench for period_capture_writer with a transaction-level reference model.
module tb_period_capture_writer;
   localparam int AW     = 10;
   localparam int DEPTH  = 1024;
   localparam int BASE_A = 0;
   localparam int BASE_B = 1000;

   typedef struct {
      int          addr;
      logic [31:0] dat;
   } wr_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic sig_in  = 1'b0;
   logic enable  = 1'b0;
   logic clear   = 1'b0;

   always #5 clk = ~clk;

   period_capture_writer_if #(.ADDR_W(AW)) bus ();
   period_capture_writer_if #(.ADDR_W(AW)) bus_b ();
   assign bus_b.avm_waitrequest = 1'b0;

   logic [AW-1:0] wr_ptr, wr_ptr_b;
   logic [31:0]   sample_count, sample_count_b;
   logic          wrapped, overrun, wrapped_b, overrun_b;
`ifdef PERIOD_CAPTURE_MINMAX_EN
   logic [31:0]   min_period, max_period, min_period_b, max_period_b;
`endif

   period_capture_writer #(.ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE_A), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .enable(enable), .clear(clear),
      .avm(bus), .wr_ptr(wr_ptr), .sample_count(sample_count), .wrapped(wrapped), .overrun(overrun)
`ifdef PERIOD_CAPTURE_MINMAX_EN
      , .min_period(min_period), .max_period(max_period)
`endif
   );

   period_capture_writer #(.ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE_B), .SYNC_STAGES(3)) dut_b (
      .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .enable(enable), .clear(clear),
      .avm(bus_b), .wr_ptr(wr_ptr_b), .sample_count(sample_count_b), .wrapped(wrapped_b), .overrun(overrun_b)
`ifdef PERIOD_CAPTURE_MINMAX_EN
      , .min_period(min_period_b), .max_period(max_period_b)
`endif
   );

   int n_checks = 0, n_pass = 0, n_fail = 0;
   int tcnt = 0, last_rise = 0;
   int exp_ptr = 0, exp_count = 0;
   bit exp_wrapped = 0, exp_overrun = 0, exp_armed = 0, stalled = 0, pend_vld = 0;
   logic [31:0] pend_dat = '0;
   logic [31:0] exp_min = 32'hFFFF_FFFF, exp_max = '0;
   wr_t exp_q[$], obs_q[$], obs_b[$];
   int wr_cyc = 0, bus_err = 0, begin_cyc = 0;
   logic prev_stall = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [31:0] prev_dat = '0;

   // Bus monitor: records committed writes and flags protocol violations.
   always @(negedge clk) begin
      if (bus.avm_write) wr_cyc++;
      if (bus.avm_byteenable !== {4{bus.avm_write}} || bus.avm_chipselect !== bus.avm_write) bus_err++;
      if (prev_stall && bus.avm_write && (bus.avm_address !== prev_addr || bus.avm_writedata !== prev_dat))
         bus_err++;
      prev_stall = bus.avm_write && bus.avm_waitrequest;
      prev_addr  = bus.avm_address;
      prev_dat   = bus.avm_writedata;
      if (bus.avm_write && !bus.avm_waitrequest)
         obs_q.push_back('{int'(bus.avm_address), bus.avm_writedata});
      if (bus_b.avm_write)
         obs_b.push_back('{int'(bus_b.avm_address), bus_b.avm_writedata});
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      tcnt++;
   endtask

   function automatic void model_commit(input logic [31:0] dat);
      exp_q.push_back('{(BASE_A + exp_ptr) % DEPTH, dat});
      exp_count++;
      exp_ptr++;
      if (exp_ptr == DEPTH) begin
         exp_ptr     = 0;
         exp_wrapped = 1'b1;
      end
   endfunction

   // A rise of sig_in: period is the distance to the previous rise.
   function automatic void model_rise();
      logic [31:0] g;
      g = 32'(tcnt - last_rise);
      last_rise = tcnt;
      if (!enable) return;
      if (!exp_armed) begin
         exp_armed = 1'b1;
         return;
      end
      if (g < exp_min) exp_min = g;
      if (g > exp_max) exp_max = g;
      if (!stalled) model_commit(g);
      else if (!pend_vld) begin
         pend_vld = 1'b1;
         pend_dat = g;
      end else exp_overrun = 1'b1;
   endfunction

   function automatic void model_clear();
      exp_ptr = 0; exp_count = 0; exp_wrapped = 0; exp_overrun = 0;
      exp_armed = 0; pend_vld = 0;
      exp_min = 32'hFFFF_FFFF; exp_max = '0;
      exp_q.delete(); obs_q.delete(); obs_b.delete();
   endfunction

   task automatic rise(input int p);
      sig_in = 1'b1;
      model_rise();
      tick();
      sig_in = 1'b0;
      repeat (p - 1) tick();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_clear();
   endtask

   task automatic check_status(input string tag);
      #1;
      chk({tag, ".wr_ptr"}, wr_ptr, exp_ptr);
      chk({tag, ".sample_count"}, sample_count, exp_count);
      chk({tag, ".wrapped"}, wrapped, exp_wrapped);
      chk({tag, ".overrun"}, overrun, exp_overrun);
`ifdef PERIOD_CAPTURE_MINMAX_EN
      chk({tag, ".min"}, min_period, exp_min);
      chk({tag, ".max"}, max_period, exp_max);
`endif
   endtask

   task automatic check_log(input string tag);
      chk({tag, ".n_writes"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         chk($sformatf("%s.addr[%0d]", tag, i), obs_q[i].addr, exp_q[i].addr);
         chk($sformatf("%s.data[%0d]", tag, i), obs_q[i].dat, exp_q[i].dat);
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   initial begin
      bus.avm_waitrequest = 1'b0;
      repeat (3) tick();
      chk("rst.avm_write", bus.avm_write, 0);
      chk("rst.byteenable", bus.avm_byteenable, 0);
      chk("rst.chipselect", bus.avm_chipselect, 0);
      chk("rst.address", bus.avm_address, 0);
      chk("rst.writedata", bus.avm_writedata, 0);
      check_status("rst");
      reset_n = 1'b1;
      enable  = 1'b1;
      repeat (2) tick();

      // Edges every 10 cycles: first arms, then three writes of 10.
      repeat (4) rise(10);
      check_log("basic");
      check_status("basic");
      chk("basic.wr_cycles", wr_cyc, 3);

      // Random periods; second instance logs the same periods from offset 1000.
      do_clear();
      begin_cyc = wr_cyc;
      repeat (31) rise(int'($urandom_range(2, 40)));
      repeat (5) tick();
      chk("rand.wr_cycles", wr_cyc - begin_cyc, 30);
      chk("base.n_writes", obs_b.size(), 30);
      for (int i = 0; i < obs_b.size() && i < exp_q.size(); i++) begin
         chk($sformatf("base.addr[%0d]", i), obs_b[i].addr, (BASE_B + i) % DEPTH);
         chk($sformatf("base.data[%0d]", i), obs_b[i].dat, exp_q[i].dat);
      end
      check_log("rand");
      check_status("rand");

      // Disabled edges are ignored; re-enable re-arms.
      enable = 1'b0;
      exp_armed = 1'b0;
      tick();
      repeat (3) rise(8);
      repeat (4) tick();
      enable = 1'b1;
      repeat (2) tick();
      repeat (3) rise(7);
      check_log("en");
      check_status("en");

      // Long stall: one period held, later ones dropped.
      repeat (5) tick();
      bus.avm_waitrequest = 1'b1;
      stalled = 1'b1;
      repeat (3) rise(10);
      #1;
      chk("stall.write", bus.avm_write, 1);
      chk("stall.addr", bus.avm_address, (BASE_A + exp_ptr) % DEPTH);
      chk("stall.data", bus.avm_writedata, pend_dat);
      chk("stall.overrun", overrun, exp_overrun);
      repeat (10) tick();
      chk("stall.addr_late", bus.avm_address, (BASE_A + exp_ptr) % DEPTH);
      chk("stall.data_late", bus.avm_writedata, pend_dat);
      bus.avm_waitrequest = 1'b0;
      stalled = 1'b0;
      if (pend_vld) model_commit(pend_dat);
      pend_vld = 1'b0;
      repeat (4) tick();
      check_log("stall");
      check_status("stall");

      // Edges 5 apart, then clear on the same cycle as an edge.
      repeat (4) rise(5);
      check_log("c5");
      check_status("c5");
      sig_in = 1'b1;
      last_rise = tcnt;
      tick();
      sig_in = 1'b0;
      tick();
      do_clear();
      repeat (4) tick();
      chk("clr.write", bus.avm_write, 0);
      check_status("clr");
      rise(5);
      check_status("clr.arm");
      rise(5);
      check_log("clr");
      check_status("clr.post");

      // Ring wrap: 1025 periods of 6.
      do_clear();
      rise(6);
      for (int i = 0; i < 1025; i++) begin
         rise(6);
         if (i == 1022) chk("wrap.pre_wrapped", wrapped, exp_wrapped);
      end
      tick();
      check_log("wrap");
      check_status("wrap");

      // Reset during a stalled write.
      bus.avm_waitrequest = 1'b1;
      stalled = 1'b1;
      rise(10);
      chk("rst2.pre_write", bus.avm_write, 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst2.write", bus.avm_write, 0);
      chk("rst2.byteenable", bus.avm_byteenable, 0);
      model_clear();
      stalled = 1'b0;
      bus.avm_waitrequest = 1'b0;
      check_status("rst2");
      tick();
      reset_n = 1'b1;
      repeat (3) tick();
      rise(8);
      check_status("rst2.arm");
      rise(8);
      check_log("rst2");
      check_status("rst2.post");

      chk("bus_protocol", bus_err, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
